spi_reg_responder: RTL and testbench

//  SPI target (mode 0, CPOL=0/CPHA=0) that answers the SoC's spi0 master in MAX3421E-style framing.

---
 rtl/spi_reg_responder.sv | 182 ++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// SPI mode-0 target with MAX3421E-style framing over a 32x8 register file shared with local logic.
// Optional build macro SPI_AUTOINC_EN: address advances after each data byte; otherwise it is fixed per frame.
module spi_reg_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] status_i,
    input  logic [4:0] usr_addr,
    output logic [7:0] usr_rdata,
    input  logic       usr_we,
    input  logic [7:0] usr_wdata,
    output logic       wr_pulse,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;

    logic [1:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic [7:0] r_next_tx;
    logic [4:0] r_addr;
    logic       r_dir;
    logic       r_oe;
    logic       r_wr_pulse;
    logic [4:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_regs [32];

    logic       w_sclk;
    logic       w_ss;
    logic       w_mosi;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_ss_fall;
    logic       w_ss_rise;
    logic       w_active;
    logic       w_bit_rise;
    logic       w_byte_done;
    logic [7:0] w_rx_next;
    logic [4:0] w_cmd_addr;
    logic [4:0] w_next_addr;
    logic       w_spi_we;

    // Pins are asynchronous to clk_clk; edges come from the synchronized level and its previous sample.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_ss_fall   = ~w_ss & r_ss_prev;
    assign w_ss_rise   = w_ss & ~r_ss_prev;

    // SCLK is honoured only inside a frame; the SS_n rise cycle still counts so a coincident 8th edge completes.
    assign w_active    = (r_state != ST_IDLE) && !w_ss_fall;
    assign w_bit_rise  = w_active && w_sclk_rise;
    assign w_byte_done = w_bit_rise && (r_bit_cnt == 3'd7);
    assign w_rx_next   = {r_rx_sr, w_mosi};
    assign w_cmd_addr  = w_rx_next[7:3];
    assign w_spi_we    = w_byte_done && (r_state == ST_DATA) && r_dir;

`ifdef SPI_AUTOINC_EN
    assign w_next_addr = r_addr + 5'd1;
`else
    assign w_next_addr = r_addr;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_sr    <= 7'd0;
            r_tx_sr    <= 8'd0;
            r_next_tx  <= 8'd0;
            r_addr     <= 5'd0;
            r_dir      <= 1'b0;
            r_oe       <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 8'd0;
        end else begin
            r_wr_pulse <= w_spi_we;
            if (w_spi_we) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_rx_next;
            end

            if (w_ss_fall) begin
                r_state   <= ST_CMD;
                r_bit_cnt <= 3'd0;
                r_tx_sr   <= status_i;
                r_oe      <= 1'b1;
            end else begin
                if (w_bit_rise) begin
                    r_rx_sr   <= w_rx_next[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end

                if (w_byte_done) begin
                    if (r_state == ST_CMD) begin
                        r_addr    <= w_cmd_addr;
                        r_dir     <= w_rx_next[1];
                        r_state   <= ST_DATA;
                        r_next_tx <= w_rx_next[1] ? 8'h00 : r_regs[w_cmd_addr];
                    end else begin
                        r_addr    <= w_next_addr;
                        r_next_tx <= r_dir ? 8'h00 : r_regs[w_next_addr];
                    end
                end

                // Load the next byte on the falling edge that ends a byte, otherwise shift out MSB-first.
                if (w_active && w_sclk_fall) begin
                    if (r_bit_cnt == 3'd0)
                        r_tx_sr <= r_next_tx;
                    else
                        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                end

                if (w_ss_rise) begin
                    r_state <= ST_IDLE;
                    r_oe    <= 1'b0;
                end
            end
        end
    end

    // SPI write takes priority when both sides target the same register in one cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= RESET_VAL;
        end else begin
            if (usr_we && !(w_spi_we && (usr_addr == r_addr)))
                r_regs[usr_addr] <= usr_wdata;
            if (w_spi_we)
                r_regs[r_addr] <= w_rx_next;
        end
    end

    assign usr_rdata   = r_regs[usr_addr];
    assign spi_miso    = r_tx_sr[7];
    assign spi_miso_oe = r_oe;
    assign wr_pulse    = r_wr_pulse;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = ~w_ss;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: directed table, corner sequences, randomized frames vs a byte-level model.
module tb_spi_reg_responder;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, ss_n, mosi, miso, miso_oe;
    logic [7:0] status;
    logic [4:0] uaddr;
    logic [7:0] urdata;
    logic       uwe;
    logic [7:0] uwdata;
    logic       wpulse;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       busy;

    spi_reg_responder #(.SYNC_STAGES(SYNC), .RESET_VAL(8'h00)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .spi_sclk(sclk), .spi_ss_n(ss_n),
        .spi_mosi(mosi), .spi_miso(miso), .spi_miso_oe(miso_oe), .status_i(status),
        .usr_addr(uaddr), .usr_rdata(urdata), .usr_we(uwe), .usr_wdata(uwdata),
        .wr_pulse(wpulse), .wr_addr(waddr), .wr_data(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int pulse_cnt = 0;
    logic [4:0] last_addr;
    logic [7:0] last_data;

    always @(negedge clk) begin
        if (rst_n && wpulse) begin
            pulse_cnt = pulse_cnt + 1;
            last_addr = waddr;
            last_data = wdata;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        uaddr = a;
        #1;
        d = urdata;
    endtask

    task automatic uwr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        uwe = 1'b1; uaddr = a; uwdata = d;
        @(negedge clk);
        uwe = 1'b0;
    endtask

    logic [7:0] f_tx [4];
    logic [7:0] f_rx [4];
    logic       coll_en = 1'b0;
    logic [4:0] coll_addr;
    logic [7:0] coll_data;

    // Master side: n bytes, the last one truncated to last_bits; MISO sampled at each SCLK rise.
    task automatic spi_frame(input int n, input int last_bits);
        int nb;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_in_frame", busy, 1);
        chk("oe_in_frame", miso_oe, 1);
        for (int b = 0; b < n; b++) begin
            f_rx[b] = 8'h00;
            nb = (b == n - 1) ? last_bits : 8;
            for (int k = 0; k < nb; k++) begin
                mosi = f_tx[b][7-k];
                repeat (HALF) @(negedge clk);
                sclk = 1'b1;
                f_rx[b][7-k] = miso;
                if (coll_en && b == n - 1 && k == 7) begin
                    repeat (SYNC) @(negedge clk);
                    uwe = 1'b1; uaddr = coll_addr; uwdata = coll_data;
                    @(negedge clk);
                    uwe = 1'b0;
                    repeat (HALF - SYNC - 1) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                sclk = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        chk("oe_after_ss_rise", miso_oe, 0);
        chk("busy_after_ss_rise", busy, 0);
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  status;
        logic        pre_we;
        logic [4:0]  pre_addr;
        logic [7:0]  pre_data;
        int          n;
        logic [23:0] tx;
        logic [23:0] exp;
        logic [4:0]  chk_addr;
        logic [7:0]  chk_val;
        int          pulses;
        logic [4:0]  last_a;
        logic [7:0]  last_d;
    } vec_t;

    vec_t vec [5];
    logic [7:0] model [32];

    initial begin
        int p0;
        logic [7:0] d;
        int n;
        logic [4:0] a;
        logic wr;
        logic [7:0] exp_rx [4];
        int exp_p;

`ifdef SPI_AUTOINC_EN
        vec[0] = '{8'h3C, 1'b0, 5'd0, 8'h00, 2, 24'h8A5C00, 24'h3C0000, 5'd17, 8'h5C, 1, 5'd17, 8'h5C};
        vec[1] = '{8'h81, 1'b1, 5'd3, 8'hA5, 2, 24'h180000, 24'h81A500, 5'd3,  8'hA5, 0, 5'd0,  8'h00};
        vec[2] = '{8'h5A, 1'b0, 5'd0, 8'h00, 3, 24'hFA1122, 24'h5A0000, 5'd31, 8'h11, 2, 5'd0,  8'h22};
        vec[3] = '{8'hC3, 1'b0, 5'd0, 8'h00, 3, 24'h880000, 24'hC35C00, 5'd17, 8'h5C, 0, 5'd0,  8'h00};
        vec[4] = '{8'h11, 1'b0, 5'd0, 8'h00, 2, 24'h000000, 24'h112200, 5'd0,  8'h22, 0, 5'd0,  8'h00};
`else
        vec[0] = '{8'h3C, 1'b0, 5'd0, 8'h00, 2, 24'h8A5C00, 24'h3C0000, 5'd17, 8'h5C, 1, 5'd17, 8'h5C};
        vec[1] = '{8'h81, 1'b1, 5'd3, 8'hA5, 2, 24'h180000, 24'h81A500, 5'd3,  8'hA5, 0, 5'd0,  8'h00};
        vec[2] = '{8'h5A, 1'b0, 5'd0, 8'h00, 3, 24'hFA1122, 24'h5A0000, 5'd31, 8'h22, 2, 5'd31, 8'h22};
        vec[3] = '{8'hC3, 1'b0, 5'd0, 8'h00, 3, 24'h880000, 24'hC35C5C, 5'd17, 8'h5C, 0, 5'd0,  8'h00};
        vec[4] = '{8'h11, 1'b0, 5'd0, 8'h00, 2, 24'h000000, 24'h110000, 5'd0,  8'h00, 0, 5'd0,  8'h00};
`endif

        rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        status = 8'h00; uaddr = 5'd0; uwe = 1'b0; uwdata = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Dirty the state, then pull reset in the middle of a frame
        status = 8'h3C;
        f_tx[0] = 8'h8A; f_tx[1] = 8'h5C;
        spi_frame(2, 8);
        uwr(5'd2, 8'h99);
        status = 8'hFF;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        chk("pre_reset_miso", miso, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_miso", miso, 0);
        chk("reset_oe", miso_oe, 0);
        chk("reset_wr_pulse", wpulse, 0);
        chk("reset_wr_addr", waddr, 0);
        chk("reset_wr_data", wdata, 0);
        chk("reset_busy", busy, 0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), d);
            chk($sformatf("reset_reg%0d", i), d, 8'h00);
        end
        ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            if (vec[v].pre_we) uwr(vec[v].pre_addr, vec[v].pre_data);
            status = vec[v].status;
            for (int b = 0; b < 3; b++) f_tx[b] = vec[v].tx[23-8*b -: 8];
            p0 = pulse_cnt;
            spi_frame(vec[v].n, 8);
            for (int b = 0; b < vec[v].n; b++)
                chk($sformatf("vec%0d_miso_byte%0d", v, b), f_rx[b], vec[v].exp[23-8*b -: 8]);
            chk($sformatf("vec%0d_pulses", v), pulse_cnt - p0, vec[v].pulses);
            if (vec[v].pulses > 0) begin
                chk($sformatf("vec%0d_wr_addr", v), last_addr, vec[v].last_a);
                chk($sformatf("vec%0d_wr_data", v), last_data, vec[v].last_d);
            end
            rd(vec[v].chk_addr, d);
            chk($sformatf("vec%0d_reg", v), d, vec[v].chk_val);
        end

        // Abort: data byte cut after 5 bits
        uwr(5'd9, 8'h77);
        status = 8'h42;
        f_tx[0] = 8'h4A; f_tx[1] = 8'hFF;
        p0 = pulse_cnt;
        spi_frame(2, 5);
        chk("abort_pulses", pulse_cnt - p0, 0);
        rd(5'd9, d);
        chk("abort_reg9", d, 8'h77);
        chk("abort_status_byte", f_rx[0], 8'h42);

        // Collisions on the byte-done cycle
        uwr(5'd5, 8'h00);
        uwr(5'd6, 8'h00);
        f_tx[0] = 8'h2A; f_tx[1] = 8'h33;
        coll_en = 1'b1; coll_addr = 5'd5; coll_data = 8'h44;
        spi_frame(2, 8);
        rd(5'd5, d);
        chk("coll_same_reg5", d, 8'h33);
        uwr(5'd5, 8'h00);
        coll_addr = 5'd6;
        spi_frame(2, 8);
        coll_en = 1'b0;
        rd(5'd5, d);
        chk("coll_other_reg5", d, 8'h33);
        rd(5'd6, d);
        chk("coll_other_reg6", d, 8'h44);

        // Randomized frames against a byte-level model
        for (int i = 0; i < 32; i++) begin
            model[i] = 8'($urandom);
            uwr(5'(i), model[i]);
        end
        for (int t = 0; t < 40; t++) begin
            for (int j = 0; j < 2; j++) begin
                a = 5'($urandom_range(0, 31));
                d = 8'($urandom);
                model[a] = d;
                uwr(a, d);
            end
            status = 8'($urandom);
            n = $urandom_range(2, 4);
            a = 5'($urandom_range(0, 31));
            wr = 1'($urandom);
            f_tx[0] = {a, 1'($urandom), wr, 1'($urandom)};
            exp_rx[0] = status;
            exp_p = 0;
            for (int b = 1; b < n; b++) begin
                f_tx[b] = 8'($urandom);
                if (wr) begin
                    exp_rx[b] = 8'h00;
                    model[a] = f_tx[b];
                    exp_p++;
                end else begin
                    exp_rx[b] = model[a];
                end
`ifdef SPI_AUTOINC_EN
                a = a + 5'd1;
`endif
            end
            p0 = pulse_cnt;
            spi_frame(n, 8);
            for (int b = 0; b < n; b++)
                chk($sformatf("rnd%0d_miso_byte%0d", t, b), f_rx[b], exp_rx[b]);
            chk($sformatf("rnd%0d_pulses", t), pulse_cnt - p0, exp_p);
        end
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), d);
            chk($sformatf("final_reg%0d", i), d, model[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
